regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_pending_tracker.sv | 76 +++++++
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 tb/tb_regfile_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizes and typedefs shared by the regfile scoreboard files
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_DATA_W-1:0] data_t;
    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_pending_tracker.sv
// rtl/regfile_pending_tracker.sv - per-register pending bits, reservation grant and pending count
module regfile_pending_tracker
    import regfile_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [DEPTH-1:0]  pending,
    output logic [ADDR_W:0]   pend_cnt
);

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;
    logic             rsv_in_range;
    logic             rsv_hit_pend;
    logic             wr_hit_pend;
    logic             rsv_take;

    always_comb begin
        rsv_in_range = 1'b0;
        rsv_hit_pend = 1'b0;
        wr_hit_pend  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_addr == ADDR_W'(i)) begin
                rsv_in_range = 1'b1;
                rsv_hit_pend = pending_q[i];
            end
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                wr_hit_pend = pending_q[i];
            end
        end

        // A write landing this cycle frees the register, so it may be re-reserved at once.
        rsv_ok   = rsv_in_range && (!rsv_hit_pend || (wr_en && (wr_addr == rsv_addr)));
        rsv_take = rsv_en && rsv_ok && !((ZERO_R0 != 0) && (rsv_addr == '0));

        pending_d = pending_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (rsv_take && (rsv_addr == ADDR_W'(i))) begin
                pending_d[i] = 1'b1;
            end
        end

        pend_cnt_d = pend_cnt_q;
        case ({rsv_take, wr_hit_pend})
            2'b10:   pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - (ADDR_W+1)'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pending  = pending_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - two-read one-write register file with reservation scoreboard (optional REGFILE_BYPASS_EN)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_busy,
    input  logic              rd2_en,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   pend_cnt
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd_data_q [2];
    logic [DATA_W-1:0] rd_data_d [2];
    logic [1:0]        rd_busy_q, rd_busy_d;
    logic [1:0]        rd_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DEPTH-1:0]  pending;

    regfile_pending_tracker #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    assign rd_en      = {rd2_en, rd1_en};
    assign rd_addr[0] = rd1_addr;
    assign rd_addr[1] = rd2_addr;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Out-of-range addresses and a hardwired r0 match no entry and read as zero, not busy.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                rd_data_d[p] = '0;
                rd_busy_d[p] = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if ((rd_addr[p] == ADDR_W'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
                        rd_data_d[p] = regs_q[i];
                        rd_busy_d[p] = pending[i] && !(wr_en && (wr_addr == rd_addr[p]));
`ifdef REGFILE_BYPASS_EN
                        if (wr_en && (wr_addr == rd_addr[p])) begin
                            rd_data_d[p] = wr_data;
                        end
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_busy_q    <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd1_data = rd_data_q[0];
    assign rd2_data = rd_data_q[1];
    assign rd1_busy = rd_busy_q[0];
    assign rd2_busy = rd_busy_q[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    int          vectors;
    int          miscompares;

    logic        a_rd1_en, a_rd2_en, a_wr_en, a_rsv_en, a_rd1_busy, a_rd2_busy, a_rsv_ok;
    logic [3:0]  a_rd1_addr, a_rd2_addr, a_wr_addr, a_rsv_addr;
    logic [15:0] a_wr_data, a_rd1_data, a_rd2_data;
    logic [4:0]  a_pend_cnt;

    logic        b_rd1_en, b_rd2_en, b_wr_en, b_rsv_en, b_rd1_busy, b_rd2_busy, b_rsv_ok;
    logic [3:0]  b_rd1_addr, b_rd2_addr, b_wr_addr, b_rsv_addr;
    logic [15:0] b_wr_data, b_rd1_data, b_rd2_data;
    logic [4:0]  b_pend_cnt;

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] EXP_BYPASS = 16'h1234;
`else
    localparam logic [15:0] EXP_BYPASS = 16'h0000;
`endif

    regfile_scoreboard u_a (
        .clk(clk), .rst_n(rst_n),
        .rd1_en(a_rd1_en), .rd1_addr(a_rd1_addr), .rd1_data(a_rd1_data), .rd1_busy(a_rd1_busy),
        .rd2_en(a_rd2_en), .rd2_addr(a_rd2_addr), .rd2_data(a_rd2_data), .rd2_busy(a_rd2_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .rsv_ok(a_rsv_ok), .pend_cnt(a_pend_cnt)
    );

    regfile_scoreboard #(.DEPTH(12), .ZERO_R0(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd1_en(b_rd1_en), .rd1_addr(b_rd1_addr), .rd1_data(b_rd1_data), .rd1_busy(b_rd1_busy),
        .rd2_en(b_rd2_en), .rd2_addr(b_rd2_addr), .rd2_data(b_rd2_data), .rd2_busy(b_rd2_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .rsv_ok(b_rsv_ok), .pend_cnt(b_pend_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_rd1_en = 0; a_rd2_en = 0; a_wr_en = 0; a_rsv_en = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_rd1_addr = 0; a_rd2_addr = 0; a_wr_addr = 0; a_rsv_addr = 0; a_wr_data = 0;
        b_rd1_en = 0; b_rd2_en = 0; b_wr_en = 0; b_rsv_en = 0;
        b_rd1_addr = 0; b_rd2_addr = 0; b_wr_addr = 0; b_rsv_addr = 0; b_wr_data = 0;
        idle_a();

        // inputs during reset are ignored
        a_rsv_en = 1; a_rsv_addr = 4'd3; a_wr_en = 1; a_wr_addr = 4'd5; a_wr_data = 16'hDEAD;
        a_rd1_en = 1; a_rd1_addr = 4'd5;
        #2;
        check("rst_rsv_ok", a_rsv_ok, 1);
        tick();
        check("rst_pend_cnt", a_pend_cnt, 0);
        check("rst_rd1_data", a_rd1_data, 0);
        idle_a();
        rst_n = 1'b1;

        a_rd1_en = 1; a_rd1_addr = 4'd5; a_rd2_en = 1; a_rd2_addr = 4'd5;
        tick();
        idle_a();
        check("r5_rd1_data", a_rd1_data, 0);
        check("r5_rd2_data", a_rd2_data, 0);
        check("r5_rd1_busy", a_rd1_busy, 0);
        check("r5_rd2_busy", a_rd2_busy, 0);
        check("r5_pend_cnt", a_pend_cnt, 0);

        a_wr_en = 1; a_wr_addr = 4'd3; a_wr_data = 16'hBEEF;
        tick();
        idle_a();
        a_rd1_en = 1; a_rd1_addr = 4'd3;
        tick();
        idle_a();
        check("r3_rd1_data", a_rd1_data, 16'hBEEF);
        a_rd1_addr = 4'd5;
        tick();
        check("rd1_hold", a_rd1_data, 16'hBEEF);

        a_wr_en = 1; a_wr_addr = 4'd4; a_wr_data = 16'h1234;
        a_rd1_en = 1; a_rd1_addr = 4'd4; a_rd2_en = 1; a_rd2_addr = 4'd3;
        tick();
        idle_a();
        check("r4_same_cycle", a_rd1_data, EXP_BYPASS);
        check("r3_rd2_data", a_rd2_data, 16'hBEEF);
        a_rd2_en = 1; a_rd2_addr = 4'd4;
        tick();
        idle_a();
        check("r4_next_read", a_rd2_data, 16'h1234);

        a_rsv_en = 1; a_rsv_addr = 4'd7;
        #1;
        check("r7_rsv_ok_free", a_rsv_ok, 1);
        tick();
        idle_a();
        check("r7_pend_cnt_1", a_pend_cnt, 1);
        a_rd1_en = 1; a_rd1_addr = 4'd7;
        tick();
        idle_a();
        check("r7_rd1_busy", a_rd1_busy, 1);
        a_rsv_en = 1; a_rsv_addr = 4'd7;
        #1;
        check("r7_rsv_ok_taken", a_rsv_ok, 0);
        tick();
        idle_a();
        check("r7_pend_cnt_stay", a_pend_cnt, 1);
        a_wr_en = 1; a_wr_addr = 4'd7; a_wr_data = 16'h7777;
        a_rd2_en = 1; a_rd2_addr = 4'd7;
        tick();
        idle_a();
        check("r7_pend_cnt_0", a_pend_cnt, 0);
        check("r7_rd2_busy_wr", a_rd2_busy, 0);
        a_rd1_en = 1; a_rd1_addr = 4'd7;
        tick();
        idle_a();
        check("r7_rd1_busy_0", a_rd1_busy, 0);
        check("r7_rd1_data", a_rd1_data, 16'h7777);

        a_rsv_en = 1; a_rsv_addr = 4'd2;
        tick();
        idle_a();
        check("r2_pend_cnt_1", a_pend_cnt, 1);
        a_wr_en = 1; a_wr_addr = 4'd2; a_wr_data = 16'h2222;
        a_rsv_en = 1; a_rsv_addr = 4'd2;
        #1;
        check("r2_rsv_ok_wr", a_rsv_ok, 1);
        tick();
        idle_a();
        check("r2_pend_cnt_stay", a_pend_cnt, 1);
        a_rd1_en = 1; a_rd1_addr = 4'd2;
        tick();
        idle_a();
        check("r2_still_busy", a_rd1_busy, 1);
        check("r2_data", a_rd1_data, 16'h2222);
        a_wr_en = 1; a_wr_addr = 4'd2; a_wr_data = 16'h2223;
        a_rsv_en = 1; a_rsv_addr = 4'd9;
        tick();
        idle_a();
        check("swap_pend_cnt", a_pend_cnt, 1);
        a_wr_en = 1; a_wr_addr = 4'd9; a_wr_data = 16'h9999;
        tick();
        idle_a();
        check("r9_clear_cnt", a_pend_cnt, 0);

        b_wr_en = 1; b_wr_addr = 4'd0; b_wr_data = 16'hFFFF;
        tick();
        b_wr_addr = 4'd13; b_wr_data = 16'hAAAA;
        tick();
        b_wr_en = 0;
        b_rd1_en = 1; b_rd1_addr = 4'd0; b_rd2_en = 1; b_rd2_addr = 4'd13;
        tick();
        b_rd1_en = 0; b_rd2_en = 0;
        check("b_r0_data", b_rd1_data, 0);
        check("b_r13_data", b_rd2_data, 0);
        check("b_r13_busy", b_rd2_busy, 0);
        b_rsv_en = 1; b_rsv_addr = 4'd13;
        #1;
        check("b_r13_rsv_ok", b_rsv_ok, 0);
        tick();
        check("b_r13_pend_cnt", b_pend_cnt, 0);
        b_rsv_addr = 4'd0;
        #1;
        check("b_r0_rsv_ok", b_rsv_ok, 1);
        tick();
        check("b_r0_pend_cnt", b_pend_cnt, 0);
        b_rsv_addr = 4'd11;
        #1;
        check("b_r11_rsv_ok", b_rsv_ok, 1);
        tick();
        check("b_r11_pend_cnt", b_pend_cnt, 1);
        b_rsv_addr = 4'd12;
        #1;
        check("b_r12_rsv_ok", b_rsv_ok, 0);
        tick();
        b_rsv_en = 0;
        b_rd1_en = 1; b_rd1_addr = 4'd11;
        tick();
        b_rd1_en = 0;
        check("b_r11_busy", b_rd1_busy, 1);

        a_rsv_en = 1; a_rsv_addr = 4'd1;
        tick();
        a_rsv_addr = 4'd2;
        tick();
        a_rsv_addr = 4'd3;
        a_rd1_en = 1; a_rd1_addr = 4'd3;
        tick();
        idle_a();
        check("pre_rst_pend_cnt", a_pend_cnt, 3);
        check("pre_rst_rd1_data", a_rd1_data, 16'hBEEF);
        a_rsv_addr = 4'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd1_data", a_rd1_data, 0);
        check("mid_rst_rd1_busy", a_rd1_busy, 0);
        check("mid_rst_pend_cnt", a_pend_cnt, 0);
        check("mid_rst_b_pend_cnt", b_pend_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_rsv_ok_r1", a_rsv_ok, 1);
        a_rd1_en = 1; a_rd1_addr = 4'd3;
        tick();
        idle_a();
        check("post_rst_r3_data", a_rd1_data, 0);
        check("post_rst_r3_busy", a_rd1_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
